decode_ctrl_stage: RTL

//  Registered decode/control stage between fetch and execute. Decodes RV32I/M/A opcodes into the core control bundle.

---
 rtl/decode_ctrl_stage.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl_stage.sv
// Decode/control stage between fetch and execute: turns RV32I/M/A words into the
// execute control bundle, held behind a valid/ready register with MDU stall timing.
module decode_ctrl_stage #(
    parameter bit          ENABLE_M = 1'b1,
    parameter bit          ENABLE_A = 1'b1,
    parameter int unsigned MUL_LAT  = 2,
    parameter int unsigned DIV_LAT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [1:0]  alu_op,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [5:0]  branch,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        mem_read,
    output logic        mem_write,
    output logic        jal,
    output logic        jalr,
    output logic        dmem_addr_sel,
    output logic        amo,
    output logic [4:0]  amo_op,
    output logic        illegal,
    output logic        mdu_start,
    output logic        mdu_abort
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_AMO    = 7'b0101111;
    localparam logic [6:0] OPC_BUBBLE = 7'b0000000;
    localparam logic [3:0] MUL_LAT_C  = 4'(MUL_LAT);
    localparam logic [3:0] DIV_LAT_C  = 4'(DIV_LAT);

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [5:0] branch;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       jal;
        logic       jalr;
        logic       dmem_addr_sel;
        logic       amo;
        logic [4:0] amo_op;
        logic       illegal;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FULL     = 2'd1,
        ST_MDU_WAIT = 2'd2
    } state_t;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    ctrl_t       dec_raw_s;
    ctrl_t       dec_s;
    logic        bad_s;
    logic        is_mdu_raw_s;
    logic        is_mdu_s;
    logic [3:0]  lat_raw_s;
    logic [3:0]  lat_s;
    logic        if_ready_s;
    logic        accept_s;

    state_t      state_d, state_q;
    logic [3:0]  cnt_d, cnt_q;
    ctrl_t       ctrl_d, ctrl_q;
    logic [31:0] instr_d, instr_q;
    logic        valid_d, valid_q;
    logic        start_d, start_q;
    logic        abort_d, abort_q;

    assign opcode_s = if_instr[6:0];
    assign funct3_s = if_instr[14:12];
    assign funct7_s = if_instr[31:25];

    // Raw opcode decode; bad_s marks encodings the configuration cannot execute
    always_comb begin
        dec_raw_s               = '0;
        dec_raw_s.dmem_addr_sel = 1'b1;
        bad_s                   = 1'b0;
        is_mdu_raw_s            = 1'b0;
        lat_raw_s               = 4'd0;
        case (opcode_s)
            OPC_R: begin
                dec_raw_s.reg_write = 1'b1;
                if (funct7_s == 7'b0000001) begin
                    if (ENABLE_M) begin
                        dec_raw_s.alu_op = 2'b11;
                        is_mdu_raw_s     = 1'b1;
                        lat_raw_s        = funct3_s[2] ? DIV_LAT_C : MUL_LAT_C;
                    end else begin
                        bad_s = 1'b1;
                    end
                end else begin
                    dec_raw_s.alu_op = 2'b10;
                end
            end
            OPC_I: begin
                dec_raw_s.alu_src_b = 2'b01;
                dec_raw_s.alu_op    = 2'b10;
                dec_raw_s.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                dec_raw_s.alu_src_b  = 2'b01;
                dec_raw_s.reg_write  = 1'b1;
                dec_raw_s.mem_to_reg = 1'b1;
                dec_raw_s.mem_read   = 1'b1;
            end
            OPC_STORE: begin
                dec_raw_s.alu_src_b = 2'b01;
                dec_raw_s.mem_write = 1'b1;
            end
            OPC_JAL: begin
                dec_raw_s.alu_src_a = 2'b01;
                dec_raw_s.alu_src_b = 2'b10;
                dec_raw_s.reg_write = 1'b1;
                dec_raw_s.jal       = 1'b1;
            end
            OPC_JALR: begin
                dec_raw_s.alu_src_a = 2'b01;
                dec_raw_s.alu_src_b = 2'b10;
                dec_raw_s.reg_write = 1'b1;
                dec_raw_s.jalr      = 1'b1;
            end
            OPC_LUI: begin
                dec_raw_s.alu_src_a = 2'b10;
                dec_raw_s.alu_src_b = 2'b01;
                dec_raw_s.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec_raw_s.alu_src_a = 2'b01;
                dec_raw_s.alu_src_b = 2'b01;
                dec_raw_s.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                dec_raw_s.alu_op = 2'b01;
                case (funct3_s)
                    3'b000:  dec_raw_s.branch = 6'b000001;
                    3'b001:  dec_raw_s.branch = 6'b000010;
                    3'b100:  dec_raw_s.branch = 6'b000100;
                    3'b101:  dec_raw_s.branch = 6'b001000;
                    3'b110:  dec_raw_s.branch = 6'b010000;
                    3'b111:  dec_raw_s.branch = 6'b100000;
                    default: bad_s = 1'b1;
                endcase
            end
            OPC_AMO: begin
                if (ENABLE_A) begin
                    dec_raw_s.alu_src_b  = 2'b11;
                    dec_raw_s.reg_write  = 1'b1;
                    dec_raw_s.mem_to_reg = 1'b1;
                    dec_raw_s.amo        = 1'b1;
                    dec_raw_s.amo_op     = funct7_s[6:2];
                    dec_raw_s.mem_read   = 1'b1;
                    // LR only reads; SC and read-modify-write AMOs also write
                    if (funct7_s[6:2] == 5'b00010) begin
                        dec_raw_s.mem_write = 1'b0;
                    end else begin
                        dec_raw_s.mem_write = 1'b1;
                    end
                end else begin
                    bad_s = 1'b1;
                end
            end
            OPC_BUBBLE: begin
                dec_raw_s = '0;
            end
            default: begin
                bad_s = 1'b1;
            end
        endcase
    end

    // Illegal encodings carry only the illegal flag so nothing downstream has side effects
    always_comb begin
        if (bad_s) begin
            dec_s               = '0;
            dec_s.illegal       = 1'b1;
            dec_s.dmem_addr_sel = 1'b1;
            is_mdu_s            = 1'b0;
            lat_s               = 4'd0;
        end else begin
            dec_s    = dec_raw_s;
            is_mdu_s = is_mdu_raw_s;
            lat_s    = lat_raw_s;
        end
    end

    assign if_ready_s = rst_n & ~flush & (state_q != ST_MDU_WAIT) &
                        ((state_q == ST_EMPTY) | id_ready);
    assign accept_s   = if_valid & if_ready_s;

    // Pipeline-register next state: flush first, then accept, then drain/count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        instr_d = instr_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
            cnt_d   = 4'd0;
            abort_d = (state_q == ST_MDU_WAIT);
        end else if (accept_s) begin
            ctrl_d  = dec_s;
            instr_d = if_instr;
            if (is_mdu_s) begin
                start_d = 1'b1;
                cnt_d   = lat_s;
                state_d = (lat_s == 4'd0) ? ST_FULL : ST_MDU_WAIT;
            end else begin
                cnt_d   = 4'd0;
                state_d = ST_FULL;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    state_d = ST_EMPTY;
                end
                ST_FULL: begin
                    state_d = id_ready ? ST_EMPTY : ST_FULL;
                end
                ST_MDU_WAIT: begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_q <= 4'd1) ? ST_FULL : ST_MDU_WAIT;
                end
                default: begin
                    state_d = ST_EMPTY;
                    cnt_d   = 4'd0;
                end
            endcase
        end
        valid_d = (state_d == ST_FULL);
    end

    // State, bundle and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            cnt_q   <= 4'd0;
            ctrl_q  <= '0;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            start_q <= start_d;
            abort_q <= abort_d;
        end
    end

    assign if_ready      = if_ready_s;
    assign id_valid      = valid_q;
    assign id_instr      = instr_q;
    assign alu_op        = ctrl_q.alu_op;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign branch        = ctrl_q.branch;
    assign reg_write     = ctrl_q.reg_write;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign jal           = ctrl_q.jal;
    assign jalr          = ctrl_q.jalr;
    assign dmem_addr_sel = ctrl_q.dmem_addr_sel;
    assign amo           = ctrl_q.amo;
    assign amo_op        = ctrl_q.amo_op;
    assign illegal       = ctrl_q.illegal;
    assign mdu_start     = start_q;
    assign mdu_abort     = abort_q;

endmodule
